bcd_frame_capture: RTL and testbench

//  Receiving end of the time-multiplexed BCD digit bus. A counter block drives one 4-bit digit with one-hot

---
 rtl/bcd_rx_pkg.sv | 8 +
 rtl/bcd_frame_capture_bcd3_to_bin.sv | 13 +
 rtl/bcd_frame_capture.sv | 139 +++++++++++++
 tb/tb_bcd_frame_capture.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_rx_pkg.sv
// bcd_rx_pkg: shared types and constants for the BCD digit-bus receiver.
package bcd_rx_pkg;
    typedef enum logic [1:0] {S_ONES, S_TENS, S_HUND} state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int DIGIT_W = 4;
    localparam int FRAME_W = 12;
    localparam int BIN_W   = 10;
endpackage

// File: rtl/bcd_frame_capture_bcd3_to_bin.sv
// bcd3_to_bin: combinational 3-digit BCD to binary via shift-add (x100 = 64+32+4, x10 = 8+2).
module bcd3_to_bin
    import bcd_rx_pkg::*;
(
    input  logic [FRAME_W-1:0] bcd,
    output logic [BIN_W-1:0]   bin
);
    logic [BIN_W-1:0] h, t, o;
    assign h   = BIN_W'(bcd[11:8]);
    assign t   = BIN_W'(bcd[7:4]);
    assign o   = BIN_W'(bcd[3:0]);
    assign bin = (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + o;
endmodule

// File: rtl/bcd_frame_capture.sv
// bcd_frame_capture: realigns slot strobes, demuxes a 3-digit BCD frame, checks range/order.
// Define BCD_BIN_EN to add the registered binary conversion on bin_value.
module bcd_frame_capture
    import bcd_rx_pkg::*;
#(
    parameter int DATA_LAG = 1,
    parameter int TIMEOUT  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] q_in,
    input  logic               en_ones,
    input  logic               en_tens,
    input  logic               en_hundreds,
    output logic [FRAME_W-1:0] bcd_value,
    output logic               frame_valid,
    output logic               digit_err,
    output logic               seq_err,
    output logic [BIN_W-1:0]   bin_value
);
    localparam int IW = $clog2(TIMEOUT);

    logic [2:0] stb;
    generate
        if (DATA_LAG == 0) begin : g_nolag
            assign stb = {en_hundreds, en_tens, en_ones};
        end else begin : g_lag
            logic [2:0] dly [DATA_LAG];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DATA_LAG; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= {en_hundreds, en_tens, en_ones};
                    for (int i = 1; i < DATA_LAG; i++) dly[i] <= dly[i-1];
                end
            end
            assign stb = dly[DATA_LAG-1];
        end
    endgenerate

    state_t state, state_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic [DIGIT_W-1:0] ones_r, tens_r, ones_nxt, tens_nxt;
    logic bad, bad_nxt, seq_nxt, dig_nxt, upd;
    logic multi, dbad;
    logic [2:0] exp_stb;
    logic [FRAME_W-1:0] frame;

    assign multi   = |(stb & (stb - 3'd1));
    assign dbad    = q_in > BCD_MAX;
    assign exp_stb = state == S_ONES ? 3'b001 : state == S_TENS ? 3'b010 : 3'b100;
    assign frame   = {q_in, tens_r, ones_r};

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        ones_nxt  = ones_r;
        tens_nxt  = tens_r;
        bad_nxt   = bad;
        seq_nxt   = 1'b0;
        dig_nxt   = 1'b0;
        upd       = 1'b0;
        if (stb == 3'b000) begin
            if (state != S_ONES) begin
                if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    seq_nxt   = 1'b1;
                    state_nxt = S_ONES;
                    idle_nxt  = '0;
                    bad_nxt   = 1'b0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end
        end else if (multi) begin
            seq_nxt   = 1'b1;
            state_nxt = S_ONES;
            idle_nxt  = '0;
            bad_nxt   = 1'b0;
        end else begin
            idle_nxt = '0;
            seq_nxt  = stb != exp_stb;
            // A stray ones strobe still starts a fresh frame
            if (stb[0]) begin
                ones_nxt  = q_in;
                dig_nxt   = dbad;
                bad_nxt   = dbad;
                state_nxt = S_TENS;
            end else if (stb != exp_stb) begin
                state_nxt = S_ONES;
                bad_nxt   = 1'b0;
            end else if (stb[1]) begin
                tens_nxt  = q_in;
                dig_nxt   = dbad;
                bad_nxt   = bad | dbad;
                state_nxt = S_HUND;
            end else begin
                dig_nxt   = dbad;
                upd       = !bad && !dbad;
                state_nxt = S_ONES;
                bad_nxt   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_ONES;
            idle_cnt    <= '0;
            ones_r      <= '0;
            tens_r      <= '0;
            bad         <= 1'b0;
            seq_err     <= 1'b0;
            digit_err   <= 1'b0;
            frame_valid <= 1'b0;
            bcd_value   <= '0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_nxt;
            ones_r      <= ones_nxt;
            tens_r      <= tens_nxt;
            bad         <= bad_nxt;
            seq_err     <= seq_nxt;
            digit_err   <= dig_nxt;
            frame_valid <= upd;
            if (upd) bcd_value <= frame;
        end
    end

`ifdef BCD_BIN_EN
    logic [BIN_W-1:0] bin_nxt;
    bcd3_to_bin u_conv (.bcd(frame), .bin(bin_nxt));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bin_value <= '0;
        else if (upd) bin_value <= bin_nxt;
    end
`else
    assign bin_value = '0;
`endif
endmodule

// File: tb/tb_bcd_frame_capture.sv
// tb_bcd_frame_capture: scoreboard bench; each slot is {strobes, digit, exp frame_valid, digit_err, seq_err}.
module tb_bcd_frame_capture;
    logic clk = 1'b0, rst_n = 1'b1;
    logic [3:0] q_in = '0;
    logic en_ones = 1'b0, en_tens = 1'b0, en_hundreds = 1'b0;
    logic [11:0] bcd_value;
    logic frame_valid, digit_err, seq_err;
    logic [9:0] bin_value;

    bcd_frame_capture #(.DATA_LAG(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .q_in(q_in), .en_ones(en_ones), .en_tens(en_tens),
        .en_hundreds(en_hundreds), .bcd_value(bcd_value), .frame_valid(frame_valid),
        .digit_err(digit_err), .seq_err(seq_err), .bin_value(bin_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fv, de, se;
        logic [11:0] bcd;
        logic [9:0] bin;
    } exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0;
    logic [3:0] prev_d = '0, m_o = '0, m_t = '0;
    logic [11:0] model_bcd = '0;

    function automatic logic [9:0] bin_of(input logic [11:0] b);
`ifdef BCD_BIN_EN
        return 10'(b[11:8] * 100 + b[7:4] * 10 + b[3:0]);
`else
        return 10'(b & 12'h000);
`endif
    endfunction

    // q_in trails its strobe by one cycle, so each slot presents the previous slot's digit
    task automatic drive(input logic [9:0] e);
        exp_t x;
        {en_hundreds, en_tens, en_ones} = e[9:7];
        q_in   = prev_d;
        prev_d = e[6:3];
        if (e[9:7] == 3'b001) m_o = e[6:3];
        if (e[9:7] == 3'b010) m_t = e[6:3];
        if (e[9:7] == 3'b100 && e[2]) model_bcd = {e[6:3], m_t, m_o};
        x.fv  = e[2];
        x.de  = e[1];
        x.se  = e[0];
        x.bcd = model_bcd;
        x.bin = bin_of(model_bcd);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        sb.delete();
        prev_d = '0;
        model_bcd = '0;
        {en_hundreds, en_tens, en_ones} = 3'b000;
        q_in = '0;
    endtask

    task automatic test_reset;
        clear_model();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bcd_value, frame_valid, digit_err, seq_err, bin_value} !== 25'd0)
            $display("FAIL reset: got bcd=%h fv=%b de=%b se=%b bin=%0d, want all 0",
                     bcd_value, frame_valid, digit_err, seq_err, bin_value);
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [9:0] t [4] = '{{3'b001, 4'd3, 3'b000}, {3'b010, 4'd2, 3'b000},
                              {3'b100, 4'd1, 3'b100}, {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL basic[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_bad_digit;
        logic [9:0] t [4] = '{{3'b001, 4'hA, 3'b010}, {3'b010, 4'd5, 3'b000},
                              {3'b100, 4'd6, 3'b000}, {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL bad_digit[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_wrap;
        logic [9:0] t [7] = '{{3'b001, 4'd9, 3'b000}, {3'b010, 4'd9, 3'b000}, {3'b100, 4'd9, 3'b100},
                              {3'b001, 4'd0, 3'b000}, {3'b010, 4'd0, 3'b000}, {3'b100, 4'd0, 3'b100},
                              {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL wrap[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_order;
        logic [9:0] t [6] = '{{3'b001, 4'd1, 3'b000}, {3'b100, 4'd2, 3'b001},
                              {3'b001, 4'd7, 3'b000}, {3'b010, 4'd8, 3'b000},
                              {3'b100, 4'd9, 3'b100}, {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL order[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_multi_hot;
        logic [9:0] t [5] = '{{3'b011, 4'd3, 3'b001}, {3'b001, 4'd4, 3'b000}, {3'b010, 4'd5, 3'b000},
                              {3'b100, 4'd6, 3'b100}, {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL multi_hot[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_timeout;
        logic [9:0] t [14] = '{{3'b001, 4'd2, 3'b000},
                               {3'b000, 4'd0, 3'b000}, {3'b000, 4'd0, 3'b000}, {3'b000, 4'd0, 3'b000},
                               {3'b000, 4'd0, 3'b000}, {3'b000, 4'd0, 3'b000}, {3'b000, 4'd0, 3'b000},
                               {3'b000, 4'd0, 3'b000}, {3'b000, 4'd0, 3'b001},
                               {3'b010, 4'd4, 3'b001},
                               {3'b001, 4'd2, 3'b000}, {3'b010, 4'd4, 3'b000}, {3'b100, 4'd1, 3'b100},
                               {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL timeout[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_stray_bad_ones;
        logic [9:0] t [8] = '{{3'b001, 4'd1, 3'b000}, {3'b001, 4'hF, 3'b011},
                              {3'b010, 4'd2, 3'b000}, {3'b100, 4'd3, 3'b000},
                              {3'b001, 4'd3, 3'b000}, {3'b010, 4'd1, 3'b000},
                              {3'b100, 4'd8, 3'b100}, {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL stray_bad_ones[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] t [7] = '{{3'b001, 4'd1, 3'b000}, {3'b010, 4'd2, 3'b000}, {3'b100, 4'd3, 3'b100},
                              {3'b001, 4'd4, 3'b000}, {3'b010, 4'd5, 3'b000}, {3'b100, 4'd6, 3'b100},
                              {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL back_to_back[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] t [3] = '{{3'b001, 4'd5, 3'b000}, {3'b010, 4'd6, 3'b000}, {3'b000, 4'd0, 3'b000}};
        logic [9:0] p [3] = '{{3'b001, 4'd9, 3'b000}, {3'b010, 4'd9, 3'b000}, {3'b100, 4'd9, 3'b100}};
        logic [9:0] f [2] = '{{3'b000, 4'd0, 3'b000}, {3'b000, 4'd0, 3'b000}};
        exp_t e;
        foreach (t[i]) begin
            drive(t[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL reset_mid[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bcd_value, frame_valid, digit_err, seq_err, bin_value} !== 25'd0)
            $display("FAIL reset_mid_clear: got bcd=%h fv=%b de=%b se=%b bin=%0d, want all 0",
                     bcd_value, frame_valid, digit_err, seq_err, bin_value);
        else passed++;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        foreach (p[i]) begin
            drive(p[i]);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                    $display("FAIL post_reset[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                             i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
                else passed++;
            end
        end
        foreach (f[i]) begin
            drive(f[i]);
            e = sb.pop_front();
            checks++;
            if ({frame_valid, digit_err, seq_err, bcd_value, bin_value} !== {e.fv, e.de, e.se, e.bcd, e.bin})
                $display("FAIL post_reset_tail[%0d]: got fv=%b de=%b se=%b bcd=%h bin=%0d, want fv=%b de=%b se=%b bcd=%h bin=%0d",
                         i, frame_valid, digit_err, seq_err, bcd_value, bin_value, e.fv, e.de, e.se, e.bcd, e.bin);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_digit();
        test_wrap();
        test_order();
        test_multi_hot();
        test_timeout();
        test_stray_bad_ones();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
